// File: rtl/pipe_pkg.sv
// Shared definitions for the register-bank ALU pipeline issue side.
// Contents:
//   - FUNC_* operation codes and the NOP/HALT code points
//   - instruction word field positions ([23:20] func, [19:16] rd, [15:12] rs1,
//     [11:8] rs2, [7:0] addr)
//   - source-operand usage decode (uses_rs1 / uses_rs2) and class helpers
//   - issue FSM state enum
package pipe_pkg;

    localparam int unsigned INSTR_W  = 24;

    localparam int unsigned FUNC_MSB = 23;
    localparam int unsigned FUNC_LSB = 20;
    localparam int unsigned RD_MSB   = 19;
    localparam int unsigned RD_LSB   = 16;
    localparam int unsigned RS1_MSB  = 15;
    localparam int unsigned RS1_LSB  = 12;
    localparam int unsigned RS2_MSB  = 11;
    localparam int unsigned RS2_LSB  = 8;
    localparam int unsigned ADDR_MSB = 7;
    localparam int unsigned ADDR_LSB = 0;

    localparam logic [3:0] FUNC_ADD    = 4'd0;
    localparam logic [3:0] FUNC_SUB    = 4'd1;
    localparam logic [3:0] FUNC_AND    = 4'd2;
    localparam logic [3:0] FUNC_PASSA  = 4'd3;
    localparam logic [3:0] FUNC_PASSB  = 4'd4;
    localparam logic [3:0] FUNC_OR     = 4'd5;
    localparam logic [3:0] FUNC_XOR    = 4'd6;
    localparam logic [3:0] FUNC_SLT    = 4'd7;
    localparam logic [3:0] FUNC_NEG    = 4'd8;
    localparam logic [3:0] FUNC_NOTB   = 4'd9;
    localparam logic [3:0] FUNC_LOAD   = 4'd10;
    localparam logic [3:0] FUNC_SHL    = 4'd11;
    localparam logic [3:0] FUNC_NOP_LO = 4'd12;
    localparam logic [3:0] FUNC_NOP_HI = 4'd14;
    localparam logic [3:0] FUNC_HALT   = 4'd15;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } issue_state_e;

    function automatic logic uses_rs1(input logic [3:0] f);
        return f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLT,
                         FUNC_PASSA, FUNC_NEG, FUNC_LOAD, FUNC_SHL};
    endfunction

    function automatic logic uses_rs2(input logic [3:0] f);
        return f inside {FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_SLT,
                         FUNC_PASSB, FUNC_NOTB};
    endfunction

    function automatic logic is_nop(input logic [3:0] f);
        return (f >= FUNC_NOP_LO) && (f <= FUNC_NOP_HI);
    endfunction

    function automatic logic is_halt(input logic [3:0] f);
        return f == FUNC_HALT;
    endfunction

endpackage

// File: rtl/raw_hazard_chk.sv
// Read-after-write hazard checker.
// Keeps a shift register of (valid, rd) for the last HazDist issue slots and flags a stall
// when a used source register of the candidate word matches a valid entry.
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset, clears history
//   clear_i        synchronous history clear (start of a new run)
//   push_valid_i   the current slot issues a real operation
//   push_rd_i      destination register of the current slot
//   rs1_i, rs2_i   candidate source registers
//   use_rs1_i/use_rs2_i  candidate actually reads that source
//   stall_o        candidate must be held back this cycle
module raw_hazard_chk #(
    parameter int unsigned HazDist = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       push_valid_i,
    input  logic [3:0] push_rd_i,
    input  logic [3:0] rs1_i,
    input  logic [3:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    output logic       stall_o
);

    logic [HazDist-1:0]      hist_valid_q, hist_valid_d;
    logic [HazDist-1:0][3:0] hist_rd_q, hist_rd_d;

    always_comb begin
        stall_o = 1'b0;
        for (int i = 0; i < int'(HazDist); i++) begin
            if (hist_valid_q[i] &&
                ((use_rs1_i && (rs1_i == hist_rd_q[i])) ||
                 (use_rs2_i && (rs2_i == hist_rd_q[i])))) begin
                stall_o = 1'b1;
            end
        end
    end

    // Entry 0 is the most recent slot; bubbles and NOPs shift in valid=0.
    always_comb begin
        hist_valid_d    = '0;
        hist_rd_d       = '0;
        hist_valid_d[0] = push_valid_i;
        hist_rd_d[0]    = push_rd_i;
        for (int i = 1; i < int'(HazDist); i++) begin
            hist_valid_d[i] = hist_valid_q[i-1];
            hist_rd_d[i]    = hist_rd_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            hist_valid_q <= '0;
            hist_rd_q    <= '0;
        end else begin
            hist_valid_q <= hist_valid_d;
            hist_rd_q    <= hist_rd_d;
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// Instruction issue unit: program store plus issue FSM feeding stage 1 of the 4-stage
// register-bank ALU pipeline. Issues one word per cycle, inserts bubbles on RAW hazards
// (no forwarding in the pipeline), runs to HALT, drains and pulses done.
// Ports:
//   clk1                         system clock, rising edge
//   rst                          synchronous active-high reset (store is not cleared)
//   prog_we/prog_waddr/prog_wdata  program store write, honoured only in IDLE or DONE
//   start                        one-cycle pulse, begins a run at pc 0 (ignored while busy)
//   func/rd/rs1/rs2/addr         issued operation fields, held through bubbles
//   issue_valid                  fields are a real operation this cycle
//   pc                           current program counter
//   busy                         high in RUN or DRAIN
//   done                         one-cycle pulse when the drain completes
//   stall_cnt                    hazard bubbles in the current run, saturating
module instr_issue_unit
    import pipe_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 64,
    parameter int unsigned PC_W       = 6,
    parameter int unsigned HAZ_DIST   = 2,
    parameter int unsigned DRAIN_CYC  = 3
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_waddr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    output logic [3:0]         func,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [7:0]         addr,
    output logic               issue_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [15:0]        stall_cnt
);

    localparam int unsigned DRAIN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_DEPTH - 1);

    issue_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] word_q, word_d;
    logic               issue_valid_q, issue_valid_d;
    logic               done_q, done_d;
    logic [15:0]        stall_cnt_q, stall_cnt_d;
    logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic [INSTR_W-1:0] prog_mem [PROG_DEPTH];
    logic [INSTR_W-1:0] cur_word;
    logic [3:0]         cur_func;
    logic               idle_like;
    logic               start_run;
    logic               do_issue;
    logic               stall;

    assign cur_word  = prog_mem[pc_q];
    assign cur_func  = cur_word[FUNC_MSB:FUNC_LSB];
    assign idle_like = (state_q == StIdle) || (state_q == StDone);
    assign start_run = start && idle_like;

    // Program store: no reset, so a program survives rst and can be rerun.
    always_ff @(posedge clk1) begin
        if (prog_we && idle_like) begin
            prog_mem[prog_waddr] <= prog_wdata;
        end
    end

    raw_hazard_chk #(
        .HazDist (HAZ_DIST)
    ) u_raw_hazard_chk (
        .clk_i        (clk1),
        .rst_i        (rst),
        .clear_i      (start_run),
        .push_valid_i (do_issue),
        .push_rd_i    (cur_word[RD_MSB:RD_LSB]),
        .rs1_i        (cur_word[RS1_MSB:RS1_LSB]),
        .rs2_i        (cur_word[RS2_MSB:RS2_LSB]),
        .use_rs1_i    (uses_rs1(cur_func)),
        .use_rs2_i    (uses_rs2(cur_func)),
        .stall_o      (stall)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        word_d        = word_q;
        issue_valid_d = 1'b0;
        done_d        = 1'b0;
        stall_cnt_d   = stall_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        do_issue      = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    pc_d        = '0;
                    stall_cnt_d = '0;
                end
            end

            StRun: begin
                // The halt-decode cycle counts as the first drain cycle, so done
                // lands DRAIN_CYC cycles after the last word is consumed.
                if (is_halt(cur_func)) begin
                    state_d     = StDrain;
                    drain_cnt_d = DRAIN_W'(1);
                end else if (is_nop(cur_func)) begin
                    if (pc_q == LAST_PC) begin
                        state_d     = StDrain;
                        drain_cnt_d = DRAIN_W'(1);
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end else if (stall) begin
                    if (stall_cnt_q != 16'hFFFF) begin
                        stall_cnt_d = stall_cnt_q + 16'd1;
                    end
                end else begin
                    do_issue      = 1'b1;
                    word_d        = cur_word;
                    issue_valid_d = 1'b1;
                    // Running off the end of the store acts as an implicit HALT.
                    if (pc_q == LAST_PC) begin
                        state_d     = StDrain;
                        drain_cnt_d = DRAIN_W'(1);
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end

            StDrain: begin
                if (drain_cnt_q >= DRAIN_W'(DRAIN_CYC - 1)) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            word_q        <= '0;
            issue_valid_q <= 1'b0;
            done_q        <= 1'b0;
            stall_cnt_q   <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            word_q        <= word_d;
            issue_valid_q <= issue_valid_d;
            done_q        <= done_d;
            stall_cnt_q   <= stall_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    assign func        = word_q[FUNC_MSB:FUNC_LSB];
    assign rd          = word_q[RD_MSB:RD_LSB];
    assign rs1         = word_q[RS1_MSB:RS1_LSB];
    assign rs2         = word_q[RS2_MSB:RS2_LSB];
    assign addr        = word_q[ADDR_MSB:ADDR_LSB];
    assign issue_valid = issue_valid_q;
    assign pc          = pc_q;
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign done        = done_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
